// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - direction codes, FSM states and sprite bitmaps for pacman_mover
package pacman_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_ADDR,
    S_REQ_CHK,
    S_CUR_ADDR,
    S_CUR_CHK,
    S_EMIT
  } state_t;

  // Bit 24 is row0/col0; each group of five is one sprite row.
  localparam logic [24:0] SPR_CLOSED = 25'b01110_11111_11111_11111_01110;
  localparam logic [24:0] SPR_RIGHT  = 25'b01110_11110_11100_11110_01110;
  localparam logic [24:0] SPR_LEFT   = 25'b01110_01111_00111_01111_01110;
  localparam logic [24:0] SPR_UP     = 25'b01010_11011_11111_11111_01110;
  localparam logic [24:0] SPR_DOWN   = 25'b01110_11111_11111_11011_01010;

endpackage

// File: rtl/pacman_sprite_sel.sv
// rtl/pacman_sprite_sel.sv - picks the 5x5 sprite bitmap from heading and mouth phase
module pacman_sprite_sel
  import pacman_pkg::*;
(
  input  logic [1:0]  cur_dir,
  input  logic        mouth,
  output logic [24:0] shape
);

  always_comb begin
    shape = SPR_CLOSED;
    if (mouth) begin
      case (cur_dir)
        DIR_RIGHT: shape = SPR_RIGHT;
        DIR_UP:    shape = SPR_UP;
        DIR_LEFT:  shape = SPR_LEFT;
        default:   shape = SPR_DOWN;
      endcase
    end
  end

endmodule

// File: rtl/pacman_mover.sv
// rtl/pacman_mover.sv - per-tick Pac-Man move resolution against the wall ROM, draw request generation
module pacman_mover
  import pacman_pkg::*;
#(
  parameter int MAX_X   = 31,
  parameter int MAX_Y   = 23,
  parameter int START_X = 15,
  parameter int START_Y = 17
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [2:0]  dir_in,
  input  logic        wall_hit,
  output logic [7:0]  wall_x,
  output logic [6:0]  wall_y,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [24:0] shape,
  output logic        go
);

  localparam logic [7:0] MAX_X8   = 8'(MAX_X);
  localparam logic [6:0] MAX_Y7   = 7'(MAX_Y);
  localparam logic [7:0] START_X8 = 8'(START_X);
  localparam logic [6:0] START_Y7 = 7'(START_Y);

  state_t      state, state_nxt;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [1:0]  cur_dir, req_dir, tgt_dir;
  logic        mouth;
  logic [7:0]  tgt_x;
  logic [6:0]  tgt_y;
  logic        tgt_rim, tgt_free;
  logic        do_move, do_stall, adopt_req, in_addr;

  // The CUR states probe along the current heading, everything else along the request.
  assign tgt_dir = (state == S_CUR_ADDR || state == S_CUR_CHK) ? cur_dir : req_dir;

  always_comb begin
    tgt_x   = x_q;
    tgt_y   = y_q;
    tgt_rim = 1'b0;
    case (tgt_dir)
      DIR_RIGHT: tgt_x = (x_q == MAX_X8) ? 8'd0 : x_q + 8'd1;
      DIR_LEFT:  tgt_x = (x_q == 8'd0) ? MAX_X8 : x_q - 8'd1;
      DIR_UP: begin
        tgt_y   = y_q - 7'd1;
        tgt_rim = (y_q == 7'd0);
      end
      default: begin
        tgt_y   = y_q + 7'd1;
        tgt_rim = (y_q == MAX_Y7);
      end
    endcase
  end

  assign tgt_free = !wall_hit && !tgt_rim;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_move   = 1'b0;
    do_stall  = 1'b0;
    adopt_req = 1'b0;
    case (state)
      S_IDLE:     if (tick) state_nxt = S_REQ_ADDR;
      S_REQ_ADDR: state_nxt = S_REQ_CHK;
      S_REQ_CHK: begin
        if (tgt_free) begin
          adopt_req = 1'b1;
          do_move   = 1'b1;
          state_nxt = S_EMIT;
        end else if (req_dir == cur_dir) begin
          do_stall  = 1'b1;
          state_nxt = S_EMIT;
        end else begin
          state_nxt = S_CUR_ADDR;
        end
      end
      S_CUR_ADDR: state_nxt = S_CUR_CHK;
      S_CUR_CHK: begin
        do_move   = tgt_free;
        do_stall  = !tgt_free;
        state_nxt = S_EMIT;
      end
      S_EMIT:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= START_X8;
      y_q     <= START_Y7;
      cur_dir <= DIR_RIGHT;
      req_dir <= DIR_RIGHT;
      mouth   <= 1'b0;
    end else begin
      if (state == S_IDLE && tick)
        req_dir <= dir_in[2] ? cur_dir : dir_in[1:0];
      if (adopt_req)
        cur_dir <= req_dir;
      if (do_move) begin
        x_q   <= tgt_x;
        y_q   <= tgt_y;
        mouth <= ~mouth;
      end else if (do_stall) begin
        mouth <= 1'b1;
      end
    end
  end

  assign in_addr = (state == S_REQ_ADDR || state == S_CUR_ADDR);
  assign wall_x  = in_addr ? tgt_x : x_q;
  assign wall_y  = in_addr ? tgt_y : y_q;
  assign x_out   = x_q;
  assign y_out   = y_q;
  assign go      = (state == S_EMIT);

  pacman_sprite_sel u_sprite_sel (
    .cur_dir (cur_dir),
    .mouth   (mouth),
    .shape   (shape)
  );

endmodule

// File: tb/tb_pacman_mover.sv
// tb/tb_pacman_mover.sv - randomized and directed self-checking bench for pacman_mover
module tb_pacman_mover;

  localparam logic [24:0] E_CLOSED = 25'b01110_11111_11111_11111_01110;
  localparam logic [24:0] E_RIGHT  = 25'b01110_11110_11100_11110_01110;
  localparam logic [24:0] E_LEFT   = 25'b01110_01111_00111_01111_01110;
  localparam logic [24:0] E_UP     = 25'b01010_11011_11111_11111_01110;
  localparam logic [24:0] E_DOWN   = 25'b01110_11111_11111_11011_01010;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [2:0]  dir_in;
  logic        wall_hit = 1'b0;
  logic [7:0]  wall_x;
  logic [6:0]  wall_y;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [24:0] shape;
  logic        go;

  int n_cmp = 0;
  int n_bad = 0;

  bit maze [0:31][0:23];
  int m_x, m_y, m_cur;
  bit m_mouth;

  pacman_mover dut (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick),
    .dir_in  (dir_in),
    .wall_hit(wall_hit),
    .wall_x  (wall_x),
    .wall_y  (wall_y),
    .x_out   (x_out),
    .y_out   (y_out),
    .shape   (shape),
    .go      (go)
  );

  always #5 clock = ~clock;

  function automatic bit rom_at(input int x, input int y);
    if (x >= 0 && x < 32 && y >= 0 && y < 24) return maze[x][y];
    return 1'b0;
  endfunction

  // Synchronous wall ROM: data follows the address by one clock.
  always @(posedge clock) wall_hit <= rom_at(int'(wall_x), int'(wall_y));

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] exp_shape(input int cur, input bit mouth);
    if (!mouth) return E_CLOSED;
    case (cur)
      0: return E_RIGHT;
      1: return E_UP;
      2: return E_LEFT;
      default: return E_DOWN;
    endcase
  endfunction

  task automatic clear_maze();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 24; j++) maze[i][j] = 1'b0;
  endtask

  task automatic target(input int d, input int x, input int y,
                        output int tx, output int ty, output bit rim);
    tx = x; ty = y; rim = 1'b0;
    case (d)
      0: tx = (x + 1) % 32;
      2: tx = (x + 31) % 32;
      1: begin ty = y - 1; rim = (y == 0); end
      default: begin ty = y + 1; rim = (y == 23); end
    endcase
  endtask

  task automatic model_step(input logic [2:0] d, output int lat,
                            output int tx, output int ty, output bit rim,
                            output int cx, output int cy, output bit crim);
    int req;
    req = d[2] ? m_cur : int'(d[1:0]);
    target(req, m_x, m_y, tx, ty, rim);
    cx = 0; cy = 0; crim = 1'b1;
    lat = 3;
    if (!rim && !maze[tx][ty]) begin
      m_cur = req; m_x = tx; m_y = ty; m_mouth = !m_mouth;
    end else if (req == m_cur) begin
      m_mouth = 1'b1;
    end else begin
      lat = 5;
      target(m_cur, m_x, m_y, cx, cy, crim);
      if (!crim && !maze[cx][cy]) begin
        m_x = cx; m_y = cy; m_mouth = !m_mouth;
      end else begin
        m_mouth = 1'b1;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0; tick = 1'b0;
    repeat (2) @(negedge clock);
    expect_eq("rst_x", x_out, 15);
    expect_eq("rst_y", y_out, 17);
    expect_eq("rst_shape", shape, E_CLOSED);
    expect_eq("rst_go", go, 0);
    expect_eq("rst_wall_x", wall_x, 15);
    expect_eq("rst_wall_y", wall_y, 17);
    reset_n = 1'b1;
    m_x = 15; m_y = 17; m_cur = 0; m_mouth = 1'b0;
  endtask

  task automatic do_move(input logic [2:0] d);
    int lat, tx, ty, cx, cy, got_lat;
    bit rim, crim;
    model_step(d, lat, tx, ty, rim, cx, cy, crim);
    @(negedge clock);
    tick = 1'b1; dir_in = d;
    @(negedge clock);
    tick = 1'b0;
    got_lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1 && !rim) begin
        expect_eq("req_addr_x", wall_x, tx);
        expect_eq("req_addr_y", wall_y, ty);
      end
      if (c == 3 && lat == 5 && !crim) begin
        expect_eq("cur_addr_x", wall_x, cx);
        expect_eq("cur_addr_y", wall_y, cy);
      end
      if (go) begin got_lat = c; break; end
      @(negedge clock);
    end
    expect_eq("latency", got_lat, lat);
    expect_eq("move_x", x_out, m_x);
    expect_eq("move_y", y_out, m_y);
    expect_eq("move_shape", shape, exp_shape(m_cur, m_mouth));
    @(negedge clock);
    expect_eq("go_one_cycle", go, 0);
    expect_eq("hold_x", x_out, m_x);
    expect_eq("hold_shape", shape, exp_shape(m_cur, m_mouth));
  endtask

  initial begin
    int lat, tx, ty, cx, cy, gos;
    bit rim, crim;
    reset_n = 1'b0; tick = 1'b0; dir_in = 3'b100;
    clear_maze();
    apply_reset();

    do_move(3'b100);
    expect_eq("first_shape", shape, E_RIGHT);

    apply_reset();
    maze[16][17] = 1'b1;
    do_move(3'b001);
    expect_eq("turn_up_y", y_out, 16);

    apply_reset();
    clear_maze();
    maze[15][16] = 1'b1;
    do_move(3'b001);
    expect_eq("fallback_x", x_out, 16);

    apply_reset();
    clear_maze();
    repeat (16) do_move(3'b010);
    expect_eq("tunnel_x", x_out, 31);
    repeat (17) do_move(3'b001);
    do_move(3'b001);
    expect_eq("top_rim_y", y_out, 0);
    expect_eq("top_rim_shape", shape, E_UP);

    // Ticks during REQ_CHK and EMIT must not start another move.
    apply_reset();
    model_step(3'b000, lat, tx, ty, rim, cx, cy, crim);
    @(negedge clock); tick = 1'b1; dir_in = 3'b000;
    @(negedge clock);
    gos = 0;
    for (int c = 1; c <= 70; c++) begin
      tick = (c == 2 || c == 3);
      if (go) gos++;
      @(negedge clock);
    end
    tick = 1'b0;
    expect_eq("ignored_tick_gos", gos, 1);
    expect_eq("ignored_tick_x", x_out, m_x);

    // Reset while the fallback probe is in CUR_CHK.
    apply_reset();
    maze[15][16] = 1'b1;
    @(negedge clock); tick = 1'b1; dir_in = 3'b001;
    @(negedge clock); tick = 1'b0;
    gos = 0;
    for (int c = 1; c <= 3; c++) begin
      if (go) gos++;
      @(negedge clock);
    end
    reset_n = 1'b0;
    #1;
    expect_eq("abort_x", x_out, 15);
    expect_eq("abort_y", y_out, 17);
    expect_eq("abort_shape", shape, E_CLOSED);
    expect_eq("abort_wall_y", wall_y, 17);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (go) gos++;
      @(negedge clock);
    end
    expect_eq("abort_no_go", gos, 0);
    m_x = 15; m_y = 17; m_cur = 0; m_mouth = 1'b0;

    clear_maze();
    repeat (10) do_move(3'b000);
    maze[m_x + 1][m_y] = 1'b1;
    do_move(3'b100);
    expect_eq("wall_hold_shape", shape, E_RIGHT);

    apply_reset();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 24; j++) maze[i][j] = ($urandom_range(0, 99) < 25);
    for (int k = 0; k < 120; k++) begin
      do_move(3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 4)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pacman_mover.md
# pacman_mover

Per-tick Pac-Man movement and sprite-frame generator. On each `tick` from `rate_divider` it resolves the requested direction against a maze wall ROM and updates the tile position. It then pulses `go` so the downstream `control5x5`/`data5x5` drawing pair erases the old 5x5 sprite and draws the new one. It replaces the ad-hoc `dir_in` handling at the top level and drives `x_in`, `y_in` and `shape` of `data5x5`.

## Interface
- `MAX_X`, 31, highest tile column (160/5 - 1)
- `MAX_Y`, 23, highest tile row (120/5 - 1)
- `START_X`, 15, reset column
- `START_Y`, 17, reset row
- `clock`  in  1  system clock (CLOCK_50)
- `reset_n`  in  1  one clock; reset is asynchronous and active-low
- `tick`  in  1  one-cycle move strobe; only acted on in IDLE
- `dir_in`  in  3  requested direction: 000 right, 001 up, 010 left, 011 down, 1xx none
- `wall_hit`  in  1  wall ROM data; 1 = tile blocked; valid one cycle after address
- `wall_x`  out  8  wall ROM column address
- `wall_y`  out  7  wall ROM row address
- `x_out`  out  8  current tile column, upper bits 0
- `y_out`  out  7  current tile row, upper bits 0
- `shape`  out  25  sprite bitmap; bit 24 = row0/col0, bit 24-(5r+c) = row r/col c
- `go`  out  1  one-cycle draw request

## Operation
- States:
  - IDLE: wait for `tick`.
  - REQ_ADDR: drive the target tile of the requested direction on `wall_x`/`wall_y`.
  - REQ_CHK: sample `wall_hit` for that target.
  - CUR_ADDR: drive the target tile of `cur_dir`.
  - CUR_CHK: sample `wall_hit` for that target.
  - EMIT: assert `go`, return to IDLE.
- On `tick` in IDLE: `req_dir` = `dir_in` if `dir_in[2]`=0, else `cur_dir`; latch `req_dir`; go to REQ_ADDR.
- In REQ_CHK:
  - If the target is free, set `cur_dir` = `req_dir`, move, go to EMIT.
  - If the target is blocked and `req_dir` = `cur_dir`, no move, go to EMIT.
  - Otherwise go to CUR_ADDR.
- In CUR_CHK: if the target is free, move along `cur_dir`; otherwise no move. Either way go to EMIT.
- Target tile:
  - Right: x+1; x = MAX_X wraps to 0.
  - Left: x-1; x = 0 wraps to MAX_X (tunnel).
  - Up: y-1. Down: y+1.
  - Up at y=0 or down at y=MAX_Y is blocked regardless of `wall_hit`. The CHK state is still spent.
- Mouth: `mouth` toggles on every successful move. When no move occurs, `mouth` is forced to open.
- `shape` = closed sprite if `mouth`=0, else the open sprite for `cur_dir`.
- `wall_x`/`wall_y` outside the ADDR states equal `x_out`/`y_out`.
- `tick` outside IDLE is ignored, not queued.

## Timing
- Reset values:
  - `x_out`=START_X, `y_out`=START_Y.
  - `cur_dir`=right, `mouth`=0, `shape`=closed.
  - `go`=0, state=IDLE.
  - `wall_x`/`wall_y` = START_X/START_Y.
- Tick sampled at edge E0. Requested path free: `go` high in the cycle after edge E0+2 (3 cycles of latency). Fallback path: `go` high after edge E0+4 (5 cycles of latency).
- `x_out`, `y_out` and `shape` update on the edge entering EMIT. They are stable while `go` is high and stay stable until the next tick's update, so `data5x5` erases at the old load and loads the new one.
- Tick spacing must be ≥ 60 cycles: the draw pass takes 2×25+2 cycles. A tick arriving during EMIT is ignored.
- Asserting `reset_n` mid-operation returns everything to its reset values immediately. No `go` is issued for the aborted move.

## Structure
- Package `pacman_pkg` holds:
  - Direction codes DIR_RIGHT/UP/LEFT/DOWN.
  - The FSM state encoding.
  - 25-bit sprite constants:
    - SPR_CLOSED 01110_11111_11111_11111_01110
    - SPR_RIGHT 01110_11110_11100_11110_01110
    - SPR_LEFT 01110_01111_00111_01111_01110
    - SPR_UP 01010_11011_11111_11111_01110
    - SPR_DOWN 01110_11111_11111_11011_01010
- Sub-module `pacman_sprite_sel`: combinational (`cur_dir`, `mouth`) → `shape`.
- Target-tile and wrap arithmetic stays in `pacman_mover`.

## Test plan
- Reset, then tick with dir_in=100 and an all-free ROM → after 3 cycles `go`=1 for one cycle, x_out=16, y_out=17, shape=SPR_RIGHT.
- Wall at (16,17), dir_in=001, free above → x_out=15, y_out=16, cur_dir=up, `go` at latency 3.
- dir_in=001 with wall at (15,16), cur_dir=right, (16,17) free → fallback, x_out=16, `go` at latency 5, two ROM addresses observed.
- Start at x=0, cur_dir=left, free → x_out=31. At y=0, dir_in=001 → blocked, shape=SPR_UP, no move.
- Tick pulsed during REQ_CHK and EMIT → ignored, exactly one `go`. Reset during CUR_CHK → outputs at reset values, no `go`.
- 10 free moves right → shape alternates SPR_CLOSED/SPR_RIGHT. Then hit a wall → shape=SPR_RIGHT held.
